iecdrv_sd_arbiter: RTL and testbench
====================================

Name: iecdrv_sd_arbiter

Overview:
- Multiplexes the SD block-request interfaces of up to four drive instances (sd_lba/sd_blk_cnt/sd_rd/sd_wr/sd_ack/sd_buff_*) onto the single host SD port served by QNICE.
- Sits directly downstream of the drive instances, in the clk_sys domain.
- Grants one drive at a time using round-robin, and holds the grant for the full host transaction.
- Routes ack and read-back data to the granted drive only.

Parameters:
- NUM_DRIVES, 4, number of drive ports (1..4).
- TIMEOUT_CYC, 24'd16_000_000, host-ack watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clk_sys-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- drv_lba  in  32*NUM_DRIVES  per-drive LBA; drive i at bits [32i+31:32i].
- drv_blk_cnt  in  6*NUM_DRIVES  per-drive block count minus one.
- drv_rd  in  NUM_DRIVES  per-drive read request, level-held until ack.
- drv_wr  in  NUM_DRIVES  per-drive write request, level-held until ack.
- drv_ack  out  NUM_DRIVES  per-drive ack; only the granted bit can be high.
- drv_buff_din  in  8*NUM_DRIVES  per-drive write data toward the host.
- drv_buff_addr  out  14  broadcast buffer address.
- drv_buff_dout  out  8  broadcast read data.
- drv_buff_wr  out  1  broadcast write strobe (each drive gates it with its own ack).
- host_lba  out  32  granted LBA.
- host_blk_cnt  out  6  granted block count.
- host_rd  out  1  host read request.
- host_wr  out  1  host write request.
- host_ack  in  1  host transfer acknowledge.
- host_buff_addr  in  14  host buffer address.
- host_buff_dout  in  8  host read data.
- host_buff_din  out  8  data from the granted drive.
- host_buff_wr  in  1  host write strobe.
- host_drive  out  2  index of the granted drive.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: clk and asynchronous active-low reset, reset_n. All of the following clear to 0 immediately: drv_ack, host_rd, host_wr, host_lba, host_blk_cnt, host_drive, busy, and the round-robin pointer. The FSM goes to IDLE. Reset during XFER abandons the transfer; the host sees its request drop.
- FSM states: IDLE, REQ, XFER, RELEASE.
- IDLE:
  - Pending vector p[i] = drv_rd[i] | drv_wr[i].
  - If any bit is set, choose the first set bit at or after rr_ptr, modulo NUM_DRIVES.
  - Register grant index, LBA, blk_cnt and direction.
  - If both rd and wr are set for the chosen drive, write wins.
  - Next state REQ. host_rd/host_wr become high one cycle after the request is first sampled.
- REQ:
  - host_rd/host_wr held high, and lba/blk_cnt held stable from the registered copy.
  - A drive dropping its request here is ignored; the transaction still completes.
  - On host_ack=1, go to XFER and deassert host_rd/host_wr in the same transition.
- XFER:
  - drv_ack[grant] = host_ack, combinational.
  - host_buff_din = drv_buff_din[grant], combinational mux.
  - drv_buff_addr, drv_buff_dout and drv_buff_wr are pass-through at all times.
  - On host_ack=0, go to RELEASE.
- RELEASE:
  - Wait until drv_rd[grant]|drv_wr[grant] is 0; minimum one cycle.
  - Then set rr_ptr = grant+1 (wrapping to 0 at NUM_DRIVES) and go to IDLE.
  - This prevents a held request from being re-granted as a new transaction.
- drv_ack bits other than the granted one are 0 in all states. drv_ack is 0 outside XFER.
- host_ack high while in IDLE is ignored.
- NUM_DRIVES=1: rr_ptr stays 0.
- Request indices ≥ NUM_DRIVES do not exist and generate no logic.

Optional Feature:
- Macro: IECDRV_SD_ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter runs in REQ and saturates at TIMEOUT_CYC.
  - On reaching it: drop host_rd/host_wr, pulse output timeout_o (1 bit, extra port) for one cycle, increment the 8-bit saturating output err_cnt, advance rr_ptr past the grant, and go to RELEASE.
- Undefined: no counter and no extra ports; REQ waits indefinitely.

Decomposition:
- Package iecdrv_sd_pkg holds:
  - typedef arb_state_t (IDLE, REQ, XFER, RELEASE);
  - constants LBA_W=32, BLK_W=6, ADDR_W=14;
  - function rr_pick(pending, ptr), returning the next index.
- One sub-module, iecdrv_rr_pick: combinational round-robin priority picker, so it can be reused by the parallel-port arbiter.

Test Plan:
- Single drive read: drv_rd[1]=1, lba=0x00000123, blk_cnt=6'd12.
  - host_rd rises the next cycle with host_lba=0x123, host_drive=1.
  - Host acks 10 cycles later: drv_ack[1] follows, drv_ack[0,2,3]=0.
  - Arbiter returns to IDLE after drv_rd[1] drops.
- Contention: drv_rd[0], drv_rd[2] and drv_wr[3] asserted together with rr_ptr=0.
  - Grant order is 0, 2, 3.
  - Re-asserting drv_rd[0] after its completion is served after drive 3.
- Write data path: drv_wr[2] with drv_buff_din[2]=0xA5 and other drives driving 0x00 → host_buff_din=0xA5 throughout XFER.
- Both rd and wr high on drive 0 → host_wr=1, host_rd=0.
- Reset mid-transfer: reset_n pulled low during XFER → host_rd/host_wr/drv_ack go to 0 asynchronously; first request after release is granted normally.
- With IECDRV_SD_ARB_TIMEOUT_EN and TIMEOUT_CYC=100, host never acks → timeout_o pulses at cycle 100 of REQ, err_cnt=1, next pending drive is granted.

Source files
------------

// File: rtl/iecdrv_sd_pkg.sv
// ----------------------------------------------------------------------------
// iecdrv_sd_pkg
// Shared types, widths and the round-robin pick function for the SD
// block-request arbiter. The same pick function is reused by other
// arbiters in this codebase.
//
// Contents:
//   arb_state_t  IDLE / REQ / XFER / RELEASE
//   LBA_W, BLK_W, ADDR_W, MAX_DRIVES
//   rr_pick()    first set bit of pending at or after ptr, modulo num
// ----------------------------------------------------------------------------
package iecdrv_sd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam int LBA_W      = 32;
   localparam int BLK_W      = 6;
   localparam int ADDR_W     = 14;
   localparam int MAX_DRIVES = 4;

   // Searches pending starting at ptr and wrapping at num (1..4).
   // ptr < num and k < num, so a single conditional subtraction is a
   // complete modulo. Returns ptr when nothing is pending.
   function automatic logic [1:0] rr_pick(input logic [3:0] pending,
                                          input logic [1:0] ptr,
                                          input logic [2:0] num);
      logic [2:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < MAX_DRIVES; k++) begin
         idx = {1'b0, ptr} + 3'(k);
         if (idx >= num) idx = idx - num;
         if (!found && (3'(k) < num) && pending[idx[1:0]]) begin
            rr_pick = idx[1:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/iecdrv_rr_pick.sv
// ----------------------------------------------------------------------------
// iecdrv_rr_pick
// Combinational round-robin priority picker for up to four requesters.
//
// Ports:
//   pending  in  N  request vector
//   ptr      in  2  round-robin start position (must be < N)
//   any      out 1  at least one request pending
//   pick     out 2  index of the first pending request at or after ptr
// ----------------------------------------------------------------------------
module iecdrv_rr_pick
   import iecdrv_sd_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] pending,
   input  logic [1:0]   ptr,
   output logic         any,
   output logic [1:0]   pick
);

   logic [MAX_DRIVES-1:0] pend_ext;

   // Requesters at or above N do not exist; their slots are tied to zero.
   // NOTE: every signal driven in always_comb gets a default first so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      pend_ext          = '0;
      pend_ext[N-1:0]   = pending;
   end

   assign any  = |pending;
   assign pick = rr_pick(pend_ext, ptr, 3'(N));

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// ----------------------------------------------------------------------------
// iecdrv_sd_arbiter
// Multiplexes the SD block-request interfaces of up to four drive instances
// onto the single host SD port. Round-robin grant, held for the whole host
// transaction; ack and read-back strobes reach only the granted drive.
//
// Optional feature (macro IECDRV_SD_ARB_TIMEOUT_EN): host-ack watchdog in
// REQ; adds ports timeout_o and err_cnt.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   drv_lba/blk_cnt/rd/wr        per-drive request (drive i in slice i)
//   drv_ack                      per-drive ack, only granted bit can be high
//   drv_buff_din                 per-drive write data toward the host
//   drv_buff_addr/dout/wr        broadcast buffer address/data/strobe
//   host_lba/blk_cnt/rd/wr       granted request toward the host
//   host_ack                     host transfer acknowledge
//   host_buff_addr/dout/wr       host buffer address/data/strobe
//   host_buff_din                write data from the granted drive
//   host_drive                   index of the granted drive
//   busy                         FSM not in IDLE
//   timeout_o, err_cnt           (optional) watchdog pulse, saturating count
// ----------------------------------------------------------------------------
module iecdrv_sd_arbiter
   import iecdrv_sd_pkg::*;
#(
   parameter int          NUM_DRIVES  = 4,
   parameter logic [23:0] TIMEOUT_CYC = 24'd16_000_000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [LBA_W*NUM_DRIVES-1:0] drv_lba,
   input  logic [BLK_W*NUM_DRIVES-1:0] drv_blk_cnt,
   input  logic [NUM_DRIVES-1:0]       drv_rd,
   input  logic [NUM_DRIVES-1:0]       drv_wr,
   output logic [NUM_DRIVES-1:0]       drv_ack,
   input  logic [8*NUM_DRIVES-1:0]     drv_buff_din,
   output logic [ADDR_W-1:0]           drv_buff_addr,
   output logic [7:0]                  drv_buff_dout,
   output logic                        drv_buff_wr,
   output logic [LBA_W-1:0]            host_lba,
   output logic [BLK_W-1:0]            host_blk_cnt,
   output logic                        host_rd,
   output logic                        host_wr,
   input  logic                        host_ack,
   input  logic [ADDR_W-1:0]           host_buff_addr,
   input  logic [7:0]                  host_buff_dout,
   output logic [7:0]                  host_buff_din,
   input  logic                        host_buff_wr,
   output logic [1:0]                  host_drive,
   output logic                        busy
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
   ,
   output logic                        timeout_o,
   output logic [7:0]                  err_cnt
`endif
);

   localparam logic [1:0] LAST = 2'(NUM_DRIVES - 1);

   arb_state_t         state, state_nxt;
   logic [1:0]         grant, rr_ptr, pick, next_ptr;
   logic               any_pend;
   logic [LBA_W-1:0]   lba_q, pick_lba;
   logic [BLK_W-1:0]   blk_q, pick_blk;
   logic               wr_q, pick_wr;
   logic               grant_req;
   logic [7:0]         grant_din;
   logic               to_hit;
   logic               release_ok;

   iecdrv_rr_pick #(.N(NUM_DRIVES)) u_pick (
      .pending (drv_rd | drv_wr),
      .ptr     (rr_ptr),
      .any     (any_pend),
      .pick    (pick)
   );

   // Slice muxes for the candidate (pick) and the current owner (grant).
   always_comb begin
      pick_lba  = '0;
      pick_blk  = '0;
      pick_wr   = 1'b0;
      grant_req = 1'b0;
      grant_din = '0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
         if (pick == 2'(i)) begin
            pick_lba = drv_lba[i*LBA_W +: LBA_W];
            pick_blk = drv_blk_cnt[i*BLK_W +: BLK_W];
            pick_wr  = drv_wr[i];   // write wins when rd and wr are both set
         end
         if (grant == 2'(i)) begin
            grant_req = drv_rd[i] | drv_wr[i];
            grant_din = drv_buff_din[i*8 +: 8];
         end
      end
   end

   assign next_ptr = (grant == LAST) ? 2'd0 : grant + 2'd1;

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
   logic [23:0] to_cnt;
   logic        to_rel;   // RELEASE entered by timeout: do not wait for drop

   // Host ack in the same cycle takes precedence over the watchdog.
   assign to_hit     = (state == REQ) && !host_ack && (to_cnt == TIMEOUT_CYC - 24'd1);
   assign timeout_o  = to_hit;
   assign release_ok = !grant_req || to_rel;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt  <= '0;
         to_rel  <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (state != REQ)
            to_cnt <= '0;
         else if (to_cnt != TIMEOUT_CYC - 24'd1)
            to_cnt <= to_cnt + 24'd1;
         if (to_hit) begin
            to_rel <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end else if (state == IDLE) begin
            to_rel <= 1'b0;
         end
      end
   end
`else
   assign to_hit     = 1'b0;
   assign release_ok = !grant_req;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_pend)    state_nxt = REQ;
         REQ:     if (host_ack)    state_nxt = XFER;
                  else if (to_hit) state_nxt = RELEASE;
         XFER:    if (!host_ack)   state_nxt = RELEASE;
         RELEASE: if (release_ok)  state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
         lba_q  <= '0;
         blk_q  <= '0;
         wr_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_pend) begin
            grant <= pick;
            lba_q <= pick_lba;
            blk_q <= pick_blk;
            wr_q  <= pick_wr;
         end
         // Advancing only after the owner drops its request keeps a held
         // request from being re-granted as a fresh transaction.
         if ((state == RELEASE && release_ok) || to_hit)
            rr_ptr <= next_ptr;
      end
   end

   assign host_rd      = (state == REQ) && !wr_q;
   assign host_wr      = (state == REQ) &&  wr_q;
   assign host_lba     = lba_q;
   assign host_blk_cnt = blk_q;
   assign host_drive   = grant;
   assign busy         = (state != IDLE);

   always_comb begin
      drv_ack = '0;
      for (int i = 0; i < NUM_DRIVES; i++)
         drv_ack[i] = (state == XFER) && (grant == 2'(i)) && host_ack;
   end

   assign host_buff_din = grant_din;
   assign drv_buff_addr = host_buff_addr;
   assign drv_buff_dout = host_buff_dout;
   assign drv_buff_wr   = host_buff_wr;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_iecdrv_sd_arbiter
// Directed bench for iecdrv_sd_arbiter (NUM_DRIVES=4). Expected values are
// hand-derived constants. With IECDRV_SD_ARB_TIMEOUT_EN defined the
// watchdog is exercised with TIMEOUT_CYC=100.
// ----------------------------------------------------------------------------
module tb_iecdrv_sd_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [32*N-1:0] drv_lba;
   logic [6*N-1:0]  drv_blk_cnt;
   logic [N-1:0]    drv_rd, drv_wr, drv_ack;
   logic [8*N-1:0]  drv_buff_din;
   logic [13:0]     drv_buff_addr, host_buff_addr;
   logic [7:0]      drv_buff_dout, host_buff_dout, host_buff_din;
   logic            drv_buff_wr, host_buff_wr;
   logic [31:0]     host_lba;
   logic [5:0]      host_blk_cnt;
   logic            host_rd, host_wr, host_ack, busy;
   logic [1:0]      host_drive;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
   logic            timeout_o;
   logic [7:0]      err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iecdrv_sd_arbiter #(.NUM_DRIVES(N), .TIMEOUT_CYC(24'd100)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .drv_lba        (drv_lba),
      .drv_blk_cnt    (drv_blk_cnt),
      .drv_rd         (drv_rd),
      .drv_wr         (drv_wr),
      .drv_ack        (drv_ack),
      .drv_buff_din   (drv_buff_din),
      .drv_buff_addr  (drv_buff_addr),
      .drv_buff_dout  (drv_buff_dout),
      .drv_buff_wr    (drv_buff_wr),
      .host_lba       (host_lba),
      .host_blk_cnt   (host_blk_cnt),
      .host_rd        (host_rd),
      .host_wr        (host_wr),
      .host_ack       (host_ack),
      .host_buff_addr (host_buff_addr),
      .host_buff_dout (host_buff_dout),
      .host_buff_din  (host_buff_din),
      .host_buff_wr   (host_buff_wr),
      .host_drive     (host_drive),
      .busy           (busy)
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
      ,
      .timeout_o      (timeout_o),
      .err_cnt        (err_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for the host request to rise.
   task automatic wait_req;
      for (int i = 0; i < 20 && !(host_rd || host_wr); i++) tick();
      check("wait_req", 32'(host_rd | host_wr), 32'd1);
   endtask

   // Completes a transaction that is currently in REQ and returns in IDLE.
   task automatic serve(input int d, input logic wr, input logic [31:0] lba);
      check("grant_drive", 32'(host_drive), 32'(d));
      check("grant_wr", 32'(host_wr), 32'(wr));
      check("grant_rd", 32'(host_rd), 32'(!wr));
      check("grant_lba", host_lba, lba);
      host_ack = 1'b1;
      tick();
      check("xfer_ack", 32'(drv_ack), 32'(1) << d);
      check("xfer_req_drop", 32'(host_rd | host_wr), 32'd0);
      host_ack = 1'b0;
      #1;
      check("ack_follow", 32'(drv_ack), 32'd0);
      tick();
      drv_rd[d] = 1'b0;
      drv_wr[d] = 1'b0;
      tick();
      check("back_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n        = 1'b0;
      drv_rd         = '0;
      drv_wr         = '0;
      host_ack       = 1'b0;
      host_buff_addr = '0;
      host_buff_dout = '0;
      host_buff_wr   = 1'b0;
      drv_buff_din   = '0;
      drv_lba        = {32'h0000_1003, 32'h0000_1002, 32'h0000_0123, 32'h0000_1000};
      drv_blk_cnt    = {6'd3, 6'd2, 6'd12, 6'd0};
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_host_rd", 32'(host_rd | host_wr), 32'd0);
      check("rst_lba", host_lba, 32'd0);
      check("rst_drive", 32'(host_drive), 32'd0);
      check("rst_ack", 32'(drv_ack), 32'd0);
      reset_n = 1'b1;

      // Host ack while idle is ignored.
      host_ack = 1'b1;
      tick(); tick();
      check("idle_ack_busy", 32'(busy), 32'd0);
      check("idle_ack_drv", 32'(drv_ack), 32'd0);
      host_ack = 1'b0;

      // Single drive read on drive 1.
      drv_rd[1] = 1'b1;
      #1;
      check("pre_sample_rd", 32'(host_rd), 32'd0);
      tick();
      check("single_rd", 32'(host_rd), 32'd1);
      check("single_lba", host_lba, 32'h123);
      check("single_blk", 32'(host_blk_cnt), 32'd12);
      check("single_drive", 32'(host_drive), 32'd1);
      for (int i = 0; i < 9; i++) tick();
      host_ack = 1'b1;
      #1;
      check("req_no_ack", 32'(drv_ack), 32'd0);
      tick();
      check("single_ack", 32'(drv_ack), 32'b0010);
      check("single_rd_drop", 32'(host_rd), 32'd0);
      host_ack = 1'b0;
      tick();
      tick(); tick();
      check("release_hold", 32'(busy), 32'd1);
      check("release_no_rd", 32'(host_rd), 32'd0);
      drv_rd[1] = 1'b0;
      tick();
      check("single_idle", 32'(busy), 32'd0);

      // Contention from a fresh pointer: order 0, 2, 3, then 0 again.
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      drv_rd[0] = 1'b1;
      drv_rd[2] = 1'b1;
      drv_wr[3] = 1'b1;
      wait_req();
      serve(0, 1'b0, 32'h1000);
      drv_rd[0] = 1'b1;
      wait_req();
      serve(2, 1'b0, 32'h1002);
      wait_req();
      serve(3, 1'b1, 32'h1003);
      wait_req();
      serve(0, 1'b0, 32'h1000);

      // Write data path and buffer pass-through.
      drv_buff_din = {8'h00, 8'hA5, 8'h00, 8'h00};
      drv_wr[2]    = 1'b1;
      wait_req();
      check("wdata_drive", 32'(host_drive), 32'd2);
      check("wdata_wr", 32'(host_wr), 32'd1);
      host_ack = 1'b1;
      tick();
      check("wdata_din0", 32'(host_buff_din), 32'hA5);
      check("wdata_ack", 32'(drv_ack), 32'b0100);
      host_buff_addr = 14'h1ABC;
      host_buff_dout = 8'h5A;
      host_buff_wr   = 1'b1;
      #1;
      check("pass_addr", 32'(drv_buff_addr), 32'h1ABC);
      check("pass_dout", 32'(drv_buff_dout), 32'h5A);
      check("pass_wr", 32'(drv_buff_wr), 32'd1);
      tick();
      check("wdata_din1", 32'(host_buff_din), 32'hA5);
      host_ack     = 1'b0;
      host_buff_wr = 1'b0;
      tick();
      drv_wr[2] = 1'b0;
      tick();
      check("wdata_idle", 32'(busy), 32'd0);
      drv_buff_din = '0;

      // Read and write both set on drive 0: write wins.
      drv_rd[0] = 1'b1;
      drv_wr[0] = 1'b1;
      wait_req();
      serve(0, 1'b1, 32'h1000);

      // Reset during XFER, then a held request is granted normally.
      drv_rd[1] = 1'b1;
      wait_req();
      host_ack = 1'b1;
      tick();
      check("mid_ack", 32'(drv_ack), 32'b0010);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ack", 32'(drv_ack), 32'd0);
      check("mid_rst_req", 32'(host_rd | host_wr), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_lba", host_lba, 32'd0);
      host_ack = 1'b0;
      tick();
      reset_n = 1'b1;
      wait_req();
      serve(1, 1'b0, 32'h123);

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
      // Host never acks: watchdog fires in the 100th REQ cycle.
      begin
         int n;
         reset_n = 1'b0;
         #1;
         reset_n = 1'b1;
         drv_rd[1] = 1'b1;
         drv_rd[2] = 1'b1;
         wait_req();
         check("to_first_drive", 32'(host_drive), 32'd1);
         n = 1;
         while (!timeout_o && n < 200) begin
            tick();
            n++;
         end
         check("to_cycle", 32'(n), 32'd100);
         tick();
         check("to_err_cnt", 32'(err_cnt), 32'd1);
         check("to_pulse_end", 32'(timeout_o), 32'd0);
         check("to_req_drop", 32'(host_rd), 32'd0);
         wait_req();
         check("to_next_drive", 32'(host_drive), 32'd2);
         drv_rd = '0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
